// File: rtl/mdu_iter_if.sv
// Operand/result handshake bundle for the iterative multiply/divide unit.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, Result
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, Result
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with single-edge handling of divide special cases.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  mdu_iter_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   hi, lo, bm, result_q;
  logic [WIDTH-1:0]   hi_nx, lo_nx, res_nx;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;
  logic               a_sgn, b_sgn, div_zero, ovf, special;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res;

  // Operand decode on the input side; only used on the accept edge.
  always_comb begin
    a_sgn    = bus.A[WIDTH-1] & (bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11));
    b_sgn    = bus.B[WIDTH-1] & (bus.op[2] ? ~bus.op[0] : ~bus.op[1]);
    a_mag    = a_sgn ? -bus.A : bus.A;
    b_mag    = b_sgn ? -bus.B : bus.B;
    div_zero = bus.op[2] & (bus.B == '0);
    ovf      = bus.op[2] & ~bus.op[0] & (bus.A == MIN) & (bus.B == '1);
    special  = div_zero | ovf;
    if (div_zero) special_res = bus.op[1] ? bus.A : '1;
    else          special_res = bus.op[1] ? '0 : MIN;
  end

  // One iteration: {hi,lo} is the running product or {remainder,quotient}.
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, bm} : '0);
    rem_sh = {hi, lo[WIDTH-1]};
    diff   = rem_sh - {1'b0, bm};
    if (op_q[2]) begin
      if (!diff[WIDTH]) begin
        hi_nx = diff[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = rem_sh[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
    end
    prod = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    if (op_q[2])
      res_nx = op_q[1] ? (neg_r ? -hi_nx : hi_nx) : (neg_q ? -lo_nx : lo_nx);
    else
      res_nx = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    case (state)
      IDLE: if (bus.in_valid) state_nx = special ? DONE : BUSY;
      BUSY: if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      bm       <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q  <= bus.op;
          neg_q <= a_sgn ^ b_sgn;
          neg_r <= a_sgn;
          if (special) begin
            result_q <= special_res;
          end else begin
            cnt <= CNT_W'(WIDTH);
            hi  <= '0;
            lo  <= a_mag;
            bm  <= b_mag;
          end
        end
        BUSY: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) result_q <= res_nx;
        end
        default: ;
      endcase
    end
  end

  assign bus.Result = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32) with hand-computed RV M results.
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mdu_iter_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.A  = a;
    bus.B  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic take;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int n;
    check({tag, "_rdy"}, {31'b0, bus.in_ready}, 32'd1);
    issue(op, a, b);
    wait_done(n);
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, bus.Result, exp);
    take();
    check({tag, "_ovl"}, {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 3'd0;
    bus.A = '0;
    bus.B = '0;
    #1;
    check("rst_rdy", {31'b0, bus.in_ready}, 32'd1);
    check("rst_ovl", {31'b0, bus.out_valid}, 32'd0);
    check("rst_res", bus.Result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset in the middle of a multiply
    issue(3'b000, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_rdy", {31'b0, bus.in_ready}, 32'd1);
    check("midrst_ovl", {31'b0, bus.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run_op("mul_6x7", 3'b000, 32'd6, 32'd7, 32'd42, W);
    run_op("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, W);

    // MULH with consumer stalled for 5 cycles
    issue(3'b001, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    check("mulh_lat", n, W);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("mulh_hold_ovl", {31'b0, bus.out_valid}, 32'd1);
      check("mulh_hold_res", bus.Result, 32'h4000_0000);
    end
    take();
    check("mulh_ovl", {31'b0, bus.out_valid}, 32'd0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W);

    // Divide with sign handling
    run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, W);
    run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, W);
    run_op("div_7_m2",  3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, W);
    run_op("rem_7_m2",  3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, W);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, W);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, W);

    // Special cases: result is present right after the accept edge
    run_op("div_by0",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_by0",  3'b110, 32'd5, 32'd0, 32'd5, 0);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("divu_min", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, W);

    // Flush at cycle 10 of a DIV
    issue(3'b100, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_rdy", {31'b0, bus.in_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    check("flush_busy_nopulse", n, 0);

    // Flush and in_valid together: no accept even for a special case
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 3'b100;
    bus.A = 32'd5;
    bus.B = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_acc_ovl", {31'b0, bus.out_valid}, 32'd0);
    check("flush_acc_rdy", {31'b0, bus.in_ready}, 32'd1);

    // Flush wins over out_ready in DONE
    issue(3'b000, 32'd11, 32'd11);
    wait_done(n);
    check("flush_done_lat", n, W);
    @(negedge clk);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_done_ovl", {31'b0, bus.out_valid}, 32'd0);
    check("flush_done_rdy", {31'b0, bus.in_ready}, 32'd1);
    run_op("mul_3x5", 3'b000, 32'd3, 32'd5, 32'd15, W);

    // Operand changes after accept are ignored
    issue(3'b101, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.op = 3'b000;
    bus.A = 32'd1;
    bus.B = 32'd1;
    wait_done(n);
    check("stab_lat", n, W - 3);
    check("stab_res", bus.Result, 32'd14);
    take();

    // in_valid held high through DONE: no accept until IDLE
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 3'b000;
    bus.A = 32'd2;
    bus.B = 32'd3;
    @(posedge clk); #1;
    wait_done(n);
    check("hold_lat", n, W);
    repeat (2) begin
      @(posedge clk); #1;
      check("hold_rdy", {31'b0, bus.in_ready}, 32'd0);
      check("hold_ovl", {31'b0, bus.out_valid}, 32'd1);
    end
    check("hold_res", bus.Result, 32'd6);
    take();
    check("hold_idle_rdy", {31'b0, bus.in_ready}, 32'd1);
    check("hold_idle_ovl", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk) bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
